echo_fx: RTL and testbench

ECHO_FX -- requirements
Module: echo_fx

---
 rtl/echo_fx.sv | 189 ++++++++++++++++++
 tb/tb_echo_fx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_fx.sv
// echo_fx -- single-tap echo/delay effect on a signed sample stream.
//
// Each accepted input sample is mixed with an attenuated copy of the
// sample stored "delay" samples earlier in a circular buffer. The result
// is saturated to the sample range. The value written back into the
// buffer is either the dry input (feed-forward echo) or the mixed output
// (feedback echo, which repeats and decays).
//
// Parameters:
//   WIDTH      - sample width, signed two's complement
//   ADDR_W     - buffer address width, buffer depth = 2**ADDR_W
//   DELAY_STEP - delay increment in samples
//   NUM_DELAYS - number of selectable delays (NUM_DELAYS*DELAY_STEP < depth)
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   sample_in  - signed input sample, captured on accept
//   in_ready   - one-cycle pulse marking a new sample_in
//   next_D     - one-cycle pulse, advances delay selection
//   next_H     - one-cycle pulse, advances attenuation selection
//   mode_fb    - 0 feed-forward, 1 feedback; captured on accept
//   out        - registered signed output sample
//   out_ready  - one-cycle pulse marking a new out
//   overrun    - sticky: an in_ready pulse arrived while busy and was dropped
module echo_fx #(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 15,
  parameter int DELAY_STEP = 4800,
  parameter int NUM_DELAYS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             in_ready,
  input  logic             next_D,
  input  logic             next_H,
  input  logic             mode_fb,
  output logic [WIDTH-1:0] out,
  output logic             out_ready,
  output logic             overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int D_W   = (NUM_DELAYS > 1) ? $clog2(NUM_DELAYS) : 1;

  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(DELAY_STEP);
  localparam logic [D_W-1:0]    D_LAST = D_W'(NUM_DELAYS - 1);
  localparam logic [WIDTH-1:0]  S_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  S_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CALC
  } state_t;

  state_t state;

  // Live selections (change at any time on next_D / next_H).
  logic [D_W-1:0]    d_idx;
  logic [ADDR_W-1:0] delay_cur;   // always (d_idx+1)*DELAY_STEP
  logic [1:0]        a_idx;

  // Per-sample values captured at accept; the in-flight sample uses these.
  logic [WIDTH-1:0]  sample_lat;
  logic              mode_lat;
  logic [ADDR_W-1:0] delay_lat;
  logic [1:0]        a_lat;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill;

  // Delay buffer; contents intentionally survive reset.
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_data;

  logic signed [WIDTH-1:0] echo;
  logic        [WIDTH:0]   sum_wide;
  logic        [WIDTH-1:0] sum_sat;
  logic        [WIDTH-1:0] wr_data;
  logic                    wr_en;

  // Echo path, sum and saturation. Only meaningful in CALC, where rd_data
  // holds the word addressed at accept.
  always_comb begin
    echo = '0;
    // Until enough samples have been written since the last delay change,
    // the addressed slot holds stale data; suppress it.
    if (fill >= delay_lat) begin
      echo = $signed(rd_data) >>> ({1'b0, a_lat} + 3'd1);
    end

    sum_wide = {sample_lat[WIDTH-1], sample_lat} + {echo[WIDTH-1], echo};

    // Overflow when the two top bits of the widened sum disagree.
    if (sum_wide[WIDTH] != sum_wide[WIDTH-1]) begin
      sum_sat = sum_wide[WIDTH] ? S_MIN : S_MAX;
    end else begin
      sum_sat = sum_wide[WIDTH-1:0];
    end

    wr_data = mode_lat ? sum_sat : sample_lat;
    wr_en   = (state == CALC);
  end

  // Synchronous buffer: one-cycle read latency. Reset forces the FSM out of
  // CALC asynchronously, so an aborted sample never reaches this write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out        <= '0;
      out_ready  <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      rd_addr    <= '0;
      fill       <= '0;
      d_idx      <= '0;
      delay_cur  <= STEP;
      a_idx      <= '0;
      sample_lat <= '0;
      mode_lat   <= 1'b0;
      delay_lat  <= STEP;
      a_lat      <= '0;
    end else begin
      out_ready <= 1'b0;

      if (in_ready && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      if (next_H) begin
        a_idx <= a_idx + 2'd1;
      end

      if (next_D) begin
        if (d_idx == D_LAST) begin
          d_idx     <= '0;
          delay_cur <= STEP;
        end else begin
          d_idx     <= d_idx + D_W'(1);
          delay_cur <= delay_cur + STEP;
        end
      end

      // A delay change restarts the fill count; if it coincides with a
      // write, the clear wins and that write is not counted.
      if (next_D) begin
        fill <= '0;
      end else if ((state == CALC) && (fill != '1)) begin
        fill <= fill + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (in_ready) begin
            sample_lat <= sample_in;
            mode_lat   <= mode_fb;
            delay_lat  <= delay_cur;
            a_lat      <= a_idx;
            rd_addr    <= wr_ptr - delay_cur;
            state      <= RD;
          end
        end
        RD: begin
          state <= CALC;
        end
        CALC: begin
          out       <= sum_sat;
          out_ready <= 1'b1;
          wr_ptr    <= wr_ptr + ADDR_W'(1);
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_fx.sv
module tb_echo_fx;

  localparam int W    = 16;
  localparam int AW   = 4;
  localparam int STEP = 4;
  localparam int ND   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  sample_in = '0;
  logic          in_ready = 1'b0;
  logic          next_D = 1'b0;
  logic          next_H = 1'b0;
  logic          mode_fb = 1'b0;
  logic [W-1:0]  out;
  logic          out_ready;
  logic          overrun;

  echo_fx #(
    .WIDTH(W),
    .ADDR_W(AW),
    .DELAY_STEP(STEP),
    .NUM_DELAYS(ND)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_in(sample_in),
    .in_ready(in_ready),
    .next_D(next_D),
    .next_H(next_H),
    .mode_fb(mode_fb),
    .out(out),
    .out_ready(out_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int val;
    int acc;
  } exp_t;

  typedef struct {
    int sample;
    bit fb;
    int exp;
  } vec_t;

  exp_t sb[$];
  vec_t tab[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;

  // Reference model: full history of written values since reset.
  int hist[$];
  int m_fill = 0;
  int m_d = 0;
  int m_a = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_step(input int s, input bit fb, input bit nd, input bit nh);
    int dly, echo, sum, w;
    if (nd) m_fill = 0;
    dly  = (m_d + 1) * STEP;
    echo = 0;
    if (m_fill >= dly) echo = hist[hist.size() - dly] >>> (m_a + 1);
    sum = s + echo;
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    w = fb ? sum : s;
    hist.push_back(w);
    if (m_fill < (1 << AW) - 1) m_fill++;
    if (nd) m_d = (m_d + 1) % ND;
    if (nh) m_a = (m_a + 1) % 4;
    return sum;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_ready with out=%0d, expected no output (cycle %0d)",
                 $signed(out), cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("out_value", int'($signed(out)), mon_e.val);
        chk("latency", cyc - mon_e.acc, 3);
      end
    end
  end

  // One accepted sample: in_ready at cycle k, next_H (optional) in the RD
  // cycle, returns in the idle cycle where out_ready is high.
  task automatic send(input int s, input bit fb, input bit nd, input bit nh,
                      input bit use_exp, input int exp_v);
    int   m;
    exp_t e;
    sample_in = W'(s);
    mode_fb   = fb;
    in_ready  = 1'b1;
    next_D    = nd;
    m = model_step(s, fb, nd, nh);
    e.val = use_exp ? exp_v : m;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_ready = 1'b0;
    next_D   = 1'b0;
    next_H   = nh;
    @(negedge clk);
    next_H = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_h();
    next_H = 1'b1;
    @(negedge clk);
    next_H = 1'b0;
    m_a = (m_a + 1) % 4;
  endtask

  task automatic pulse_d();
    next_D = 1'b1;
    @(negedge clk);
    next_D = 1'b0;
    m_fill = 0;
    m_d = (m_d + 1) % ND;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_ready = 1'b0;
    next_D   = 1'b0;
    next_H   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    hist.delete();
    m_fill = 0;
    m_d = 0;
    m_a = 0;
  endtask

  task automatic run_tab();
    foreach (tab[i]) send(tab[i].sample, tab[i].fb, 1'b0, 1'b0, 1'b1, tab[i].exp);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int decay[10];
    int n0;
    decay = '{1000, 500, 250, 125, 62, 31, 15, 7, 3, 1};

    // Reset state after 10 idle cycles.
    @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_out_ready", int'(out_ready), 0);
    chk("reset_overrun", int'(overrun), 0);

    // Feed-forward impulse, delay 4, shift 1.
    tab.delete();
    for (int i = 0; i < 12; i++)
      tab.push_back('{(i == 0) ? 1000 : 0, 1'b0, (i == 0) ? 1000 : ((i == 4) ? 500 : 0)});
    run_tab();

    // Feedback impulse over 40 samples (buffer wraps at 16).
    do_reset();
    tab.delete();
    for (int i = 0; i < 40; i++)
      tab.push_back('{(i == 0) ? 1000 : 0, 1'b1, ((i % 4) == 0) ? decay[i / 4] : 0});
    run_tab();

    // Attenuation a_idx=2 -> shift 3; then wrap back to 0 via model.
    do_reset();
    pulse_h();
    pulse_h();
    tab.delete();
    for (int i = 0; i < 8; i++)
      tab.push_back('{(i == 0) ? 1000 : 0, 1'b0, (i == 0) ? 1000 : ((i == 4) ? 125 : 0)});
    run_tab();
    pulse_h();
    pulse_h();
    for (int i = 0; i < 8; i++) send((i == 0) ? -1000 : 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drain();

    // Saturation, both rails.
    do_reset();
    tab.delete();
    for (int i = 0; i < 10; i++) tab.push_back('{32767, 1'b0, 32767});
    run_tab();
    do_reset();
    tab.delete();
    for (int i = 0; i < 10; i++) tab.push_back('{-32768, 1'b0, -32768});
    run_tab();

    // Delay change 4 -> 8 after 20 samples of 800.
    do_reset();
    for (int i = 0; i < 20; i++) send(800, 1'b0, 1'b0, 1'b0, 1'b1, (i < 4) ? 800 : 1200);
    pulse_d();
    for (int i = 0; i < 12; i++) send(800, 1'b0, 1'b0, 1'b0, 1'b1, (i < 8) ? 800 : 1200);
    drain();

    // Delay index wrap: 12, then back to 4.
    do_reset();
    pulse_d();
    pulse_d();
    for (int i = 0; i < 16; i++) send((i == 0) ? 2000 : 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    pulse_d();
    for (int i = 0; i < 8; i++) send((i == 0) ? 2000 : 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drain();

    // next_D coincident with accept, next_H while in flight.
    do_reset();
    for (int i = 0; i < 6; i++) send(300 * (i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send(5000, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 12; i++) send(100 * i - 400, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drain();

    // Random mix.
    for (int i = 0; i < 60; i++)
      send(int'($urandom_range(40000)) - 20000, 1'($urandom_range(1)),
           $urandom_range(9) == 0, $urandom_range(4) == 0, 1'b0, 0);
    drain();

    // Overrun: in_ready during RD and during CALC are dropped.
    do_reset();
    chk("overrun_before", int'(overrun), 0);
    begin
      exp_t e;
      sample_in = W'(1234);
      mode_fb   = 1'b0;
      in_ready  = 1'b1;
      e.val = model_step(1234, 1'b0, 1'b0, 1'b0);
      e.acc = cyc;
      sb.push_back(e);
      @(negedge clk);
      sample_in = W'(9999);
      @(negedge clk);
      sample_in = W'(-7777);
      @(negedge clk);
      in_ready = 1'b0;
    end
    chk("overrun_set", int'(overrun), 1);
    for (int i = 0; i < 8; i++) send((i == 3) ? 4000 : 10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drain();
    chk("overrun_sticky", int'(overrun), 1);
    do_reset();
    chk("overrun_cleared", int'(overrun), 0);

    // Reset mid-flight: no output for the aborted sample.
    send(700, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drain();
    n0 = n_out;
    sample_in = W'(555);
    in_ready  = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    hist.delete();
    m_fill = 0;
    m_d = 0;
    m_a = 0;
    repeat (6) @(negedge clk);
    chk("abort_no_out", n_out, n0);
    chk("abort_out_zero", int'(out), 0);
    for (int i = 0; i < 8; i++) send((i == 0) ? -600 : 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
